// File: rtl/demux_route_ctrl_pkg.sv
// Shared definitions for the demux route controller.
//   state_t       : controller FSM states (IDLE, BURST)
//   DEF_DATA_W    : default data word width
//   DEF_BURST_LEN : default words per round-robin burst
package demux_route_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/demux_route_ctrl_if.sv
// Source/consumer handshake bundle for the demux route controller.
//   mode, in_data, in_dest, in_valid, in_ready : source side
//   outN_data, outN_valid, outN_ready          : consumer side, N = 0/1
// slave  : controller view
// master : environment view (drives source and consumer ready)
interface demux_route_ctrl_if #(
  parameter int DATA_W = demux_route_ctrl_pkg::DEF_DATA_W
);
  logic              mode;
  logic [DATA_W-1:0] in_data;
  logic              in_dest;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready;

  modport slave (
    input  mode, in_data, in_dest, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  modport master (
    output mode, in_data, in_dest, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
endinterface

// File: rtl/demux_route_ctrl_demux.sv
// 1-to-2 demux: din goes to dout0 when sel = 0, to dout1 when sel = 1;
// the unselected output is driven to zero.
//   sel   : channel select
//   din   : input word
//   dout0 : channel 0 output
//   dout1 : channel 1 output
module demux_1to2 #(
  parameter int W = 16
) (
  input  logic         sel,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout0,
  output logic [W-1:0] dout1
);
  assign dout0 = sel ? '0  : din;
  assign dout1 = sel ? din : '0;
endmodule

// File: rtl/demux_route_ctrl_slot.sv
// One-word output slot. Load has priority over drain so a same-cycle
// drain+load keeps the slot valid with the new word.
//   clk, rst_n : clock, async active-low reset
//   load       : capture load_data, set valid
//   drain      : consumer took the word; clear data and valid
//   load_data  : word to capture
//   data       : slot word (zero when empty)
//   valid      : slot holds a word
module route_slot #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              valid
);
  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (drain) begin
      data_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/demux_route_ctrl.sv
// Demux route controller: steers source words into two one-word output
// slots, either by tag (mode 0) or in round-robin bursts of BURST_LEN
// words (mode 1).
//   clk, rst_n : clock, async active-low reset
//   bus        : source/consumer handshake (slave view)
//   sel        : current target channel (combinational)
//   cnt0, cnt1 : accepted-word counters per channel, wrapping
//   busy       : high while the FSM is in BURST
//
// state | meaning
// IDLE  | between bursts; mode sampled every cycle
// BURST | round-robin burst in progress; mode frozen in mode_q
module demux_route_ctrl
  import demux_route_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_route_ctrl_if.slave   bus,
  output logic                sel,
  output logic [15:0]         cnt0,
  output logic [15:0]         cnt1,
  output logic                busy
);
  localparam logic [7:0] BURST_LEN_C = BURST_LEN[7:0];

  state_t      state_d, state_q;
  logic        mode_d, mode_q;
  logic        rr_ptr_d, rr_ptr_q;
  logic [7:0]  burst_cnt_d, burst_cnt_q;
  logic        busy_d, busy_q;
  logic [15:0] cnt0_d, cnt0_q, cnt1_d, cnt1_q;

  logic              mode_eff, target, accept;
  logic              drain0, drain1;
  logic [DATA_W-1:0] dmx0, dmx1;

  // In IDLE the live mode decides (it is what gets sampled this edge);
  // inside a burst the frozen copy rules.
  assign mode_eff = (state_q == IDLE) ? bus.mode : mode_q;
  assign target   = mode_eff ? rr_ptr_q : bus.in_dest;
  assign sel      = target;

  assign drain0 = bus.out0_valid & bus.out0_ready;
  assign drain1 = bus.out1_valid & bus.out1_ready;

  // Only the target slot gates readiness; never fall back to the other.
  assign bus.in_ready = target ? (~bus.out1_valid | drain1)
                               : (~bus.out0_valid | drain0);
  assign accept = bus.in_valid & bus.in_ready;

  demux_1to2 #(.W(DATA_W)) u_demux (
    .sel   (sel),
    .din   (bus.in_data),
    .dout0 (dmx0),
    .dout1 (dmx1)
  );

  route_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept & ~target),
    .drain     (drain0),
    .load_data (dmx0),
    .data      (bus.out0_data),
    .valid     (bus.out0_valid)
  );

  route_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept & target),
    .drain     (drain1),
    .load_data (dmx1),
    .data      (bus.out1_data),
    .valid     (bus.out1_valid)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        mode_d = bus.mode;
        if (accept && bus.mode) begin
          if (BURST_LEN > 1) begin
            state_d     = BURST;
            burst_cnt_d = 8'd1;
          end else begin
            rr_ptr_d = ~rr_ptr_q;
          end
        end
      end
      BURST: begin
        if (accept) begin
          if (burst_cnt_q + 8'd1 == BURST_LEN_C) begin
            state_d     = IDLE;
            burst_cnt_d = 8'd0;
            rr_ptr_d    = ~rr_ptr_q;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BURST);
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && !target) cnt0_d = cnt0_q + 16'd1;
    if (accept &&  target) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
      cnt0_q      <= 16'd0;
      cnt1_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign busy = busy_q;
  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
endmodule

// File: doc/demux_route_ctrl.md
DEMUX_ROUTE_CTRL -- requirements
Module: demux_route_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of the data word.
REQ-002 Parameter BURST_LEN, default 4, words per round-robin burst (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mode  input  1  routing mode: 0 = tagged (word goes where in_dest says), 1 = round-robin bursts.
REQ-006 in_data  input  DATA_W  source word.
REQ-007 in_dest  input  1  destination tag, used in mode 0 only.
REQ-008 in_valid  input  1  source word present.
REQ-009 in_ready  output  1  controller accepts the word this cycle.
REQ-010 out0_data / out1_data  output  DATA_W  slot data for channel 0 / 1.
REQ-011 out0_valid / out1_valid  output  1  slot holds a word.
REQ-012 out0_ready / out1_ready  input  1  consumer takes the slot word.
REQ-013 sel  output  1  current target channel (the select driving the demux datapath).
REQ-014 cnt0 / cnt1  output  16  accepted-word counters per channel.
REQ-015 busy  output  1  high while state = BURST.

Function
REQ-016 The block SHALL accept a word when in_valid & in_ready (an "accept").
REQ-017 Target channel: mode 0 -> in_dest; mode 1 -> round-robin pointer rr_ptr; sel SHALL equal the target combinationally.
REQ-018 in_ready SHALL be high iff the target slot is empty or is drained in the same cycle (outN_valid & outN_ready).
REQ-019 On accept, the target slot SHALL load in_data and set outN_valid on the next edge (latency 1 cycle).
REQ-020 A slot SHALL clear outN_valid and zero outN_data on drain unless refilled in the same cycle; on simultaneous drain+accept, valid stays 1 and data is replaced.
REQ-021 The non-targeted slot SHALL be unaffected by an accept (holds its data or stays zero).
REQ-022 FSM states: IDLE, BURST. In IDLE, mode is sampled into mode_q; mode_q is used until the next return to IDLE.
REQ-023 IDLE -> BURST on accept with mode_q = 1 and BURST_LEN > 1; the burst counter is loaded to 1.
REQ-024 In BURST, each accept increments the burst counter; on the accept that makes it equal BURST_LEN, the block SHALL toggle rr_ptr and return to IDLE.
REQ-025 BURST_LEN = 1: each mode-1 accept toggles rr_ptr and the FSM stays in IDLE.
REQ-026 In mode 0 the FSM SHALL stay in IDLE; rr_ptr SHALL be unchanged.
REQ-027 A mode change during BURST SHALL be ignored until the burst completes.
REQ-028 A stalled target (slot full, consumer not ready) SHALL hold in_ready low; the other channel SHALL NOT be selected instead.
REQ-029 cnt0/cnt1 SHALL increment by 1 per accept to that channel and wrap from 0xFFFF to 0x0000.
REQ-030 busy SHALL be high exactly while state = BURST.

Reset
REQ-031 Asserting rst_n low SHALL immediately force: state IDLE, rr_ptr 0, burst counter 0, mode_q 0, out0/out1_valid 0, out0/out1_data 0, cnt0/cnt1 0.
REQ-032 Reset mid-burst SHALL abandon the burst; the first word after reset in mode 1 goes to channel 0.
REQ-033 No accept SHALL occur on the first edge at which rst_n is low.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, BURST) and the default DATA_W and BURST_LEN constants.
REQ-035 The output slot SHALL be one sub-module, route_slot (load, drain, data, valid), instantiated twice.
REQ-036 The datapath SHALL reuse the team's 1-to-2 16-bit demux, driven by sel, to steer in_data into the slots.

Verification
REQ-037 Mode 0, both ready=1, dest sequence 0,1,1,0 with data 0x1111..0x4444 -> out0 gets 0x1111, 0x4444; out1 gets 0x2222, 0x3333; each 1 cycle after accept; cnt0 = 2, cnt1 = 2.
REQ-038 Mode 1, BURST_LEN = 4, 10 back-to-back words -> words 1-4 to ch0, 5-8 to ch1, 9-10 to ch0; busy high during each burst.
REQ-039 Mode 0, out0_ready = 0, two words with dest 0 -> first fills slot 0; in_ready low for the second until out0_ready rises; out1 untouched.
REQ-040 Mode 1, toggle mode to 0 after word 2 of a burst -> words 3-4 still go to ch0 by round-robin; the next word routes by in_dest.
REQ-041 rst_n pulsed low after word 2 of a mode-1 burst -> all outputs zero immediately; the next word goes to ch0 and starts a new burst of 4.
REQ-042 Preload cnt1 to 0xFFFF via 65535 accepts, then one more accept to ch1 -> cnt1 = 0x0000; full slot drained and refilled in the same cycle keeps out1_valid = 1 with the new data.
